// File: rtl/wb_mem_pkg.sv
// Shared constants for the QSPI bring-up memory slave: FSM encoding, lane count, wait counter width.
// Parity helpers are used only when WB_MEM_PARITY_EN is defined.
package wb_mem_pkg;

  localparam int LANES  = 4;
  localparam int WCNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Request captured at the accepting edge; bad is decoded once, up front.
  typedef struct packed {
    logic             we;
    logic             bad;
    logic [LANES-1:0] sel;
    logic [31:0]      dat;
  } req_t;

  // Even parity per byte: the stored bit makes each byte+bit have an even count of ones.
  function automatic logic [LANES-1:0] lane_parity(input logic [31:0] w);
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/wb_mem_sp_ram.sv
// Single-port byte-write-enable RAM with registered output.
// WB_MEM_PARITY_EN adds a 4-bit parity side array written with the same lane enables.
module wb_mem_sp_ram
  import wb_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
`ifdef WB_MEM_PARITY_EN
  input  logic [LANES-1:0]  din_par,
  output logic [LANES-1:0]  dout_par,
`endif
  output logic [31:0]       dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= din[8*i +: 8];
          end
        end
      end
      dout <= mem[addr];
    end
  end

`ifdef WB_MEM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            par_mem[addr][i] <= din_par[i];
          end
        end
      end
      dout_par <= par_mem[addr];
    end
  end
`endif

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave for the QSPI bring-up memory: wait states, ERR on bad address,
// registered reads. Define WB_MEM_PARITY_EN to store and check per-byte even parity.
//
// Handshake: a request is taken when cyc&stb are high in IDLE and no response is
// showing; ack or err is a one-cycle pulse, and the cycle carrying it never accepts.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int AW        = 9,
  parameter int MEM_WORDS = 512,
  parameter int WAIT_CYC  = 0
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wbs_adr_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        acc_busy
);

  localparam int RAW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [1:0]        state;
  logic [WCNT_W-1:0] wcnt;
  req_t              req_q;
  logic [RAW-1:0]    idx_q;
  logic [31:0]       ram_dout;
  logic              ram_en;
  logic              par_bad;
  logic              bad_now;
  logic [AW-1:0]     widx;

  assign widx    = wbs_adr_i[AW+1:2];
  assign bad_now = (wbs_adr_i[1:0] != 2'b00)
                 | ({{(32-AW){1'b0}}, widx} >= 32'(MEM_WORDS))
                 | (wbs_adr_i[31:AW+2] != '0);

  assign ram_en   = (state == ST_ACCESS) && !req_q.bad;
  assign acc_busy = (state != ST_IDLE);

`ifdef WB_MEM_PARITY_EN
  logic [LANES-1:0] ram_dout_par;
  assign par_bad = (lane_parity(ram_dout) != ram_dout_par);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The response cycle still sees the master's stb; skipping it costs one bubble.
          if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o) begin
            req_q.we  <= wbs_we_i;
            req_q.bad <= bad_now;
            req_q.sel <= wbs_sel_i;
            req_q.dat <= wbs_dat_i;
            idx_q     <= wbs_adr_i[RAW+1:2];
            wcnt      <= '0;
            state     <= (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (wcnt == WCNT_W'(WAIT_CYC - 1)) begin
            wcnt  <= '0;
            state <= ST_ACCESS;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (req_q.bad) begin
            wbs_err_o <= 1'b1;
          end else if (!req_q.we) begin
            wbs_dat_o <= ram_dout;
            if (par_bad) begin
              wbs_err_o <= 1'b1;
            end else begin
              wbs_ack_o <= 1'b1;
            end
          end else begin
            wbs_ack_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_mem_sp_ram #(
    .ADDR_W(RAW),
    .DEPTH (MEM_WORDS)
  ) u_ram (
    .clk     (sys_clk),
    .en      (ram_en),
    .we      (req_q.we),
    .be      (req_q.sel),
    .addr    (idx_q),
    .din     (req_q.dat),
`ifdef WB_MEM_PARITY_EN
    .din_par (lane_parity(req_q.dat)),
    .dout_par(ram_dout_par),
`endif
    .dout    (ram_dout)
  );

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: dut0 has no wait states (512 words), dut1 has
// WAIT_CYC=3 and 256 words. The parity scenario follows WB_MEM_PARITY_EN.
module tb_wb_mem_slave;

  logic              sys_clk;
  logic              rst;
  logic [1:0]        cyc, stb, we, ack, err, busy;
  logic [1:0][31:0]  adr, dati, dato;
  logic [1:0][3:0]   sel;

  int n_checks;
  int n_fail;

  wb_mem_slave #(.AW(9), .MEM_WORDS(512), .WAIT_CYC(0)) dut0 (
    .sys_clk(sys_clk), .rst(rst),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_adr_i(adr[0]), .wbs_we_i(we[0]),
    .wbs_dat_i(dati[0]), .wbs_sel_i(sel[0]), .wbs_dat_o(dato[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .acc_busy(busy[0])
  );

  wb_mem_slave #(.AW(9), .MEM_WORDS(256), .WAIT_CYC(3)) dut1 (
    .sys_clk(sys_clk), .rst(rst),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_adr_i(adr[1]), .wbs_we_i(we[1]),
    .wbs_dat_i(dati[1]), .wbs_sel_i(sel[1]), .wbs_dat_o(dato[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .acc_busy(busy[1])
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver: called just after a rising edge; returns samples-until-response (or -1).
  task automatic wb_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s, input bit b2b,
                         output int lat, output logic r_ack, output logic r_err,
                         output logic [31:0] rd);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = wd; sel[d] = s;
    lat = -1; r_ack = 1'b0; r_err = 1'b0; rd = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge sys_clk); #1;
      if (ack[d] || err[d]) begin
        lat = i; r_ack = ack[d]; r_err = err[d]; rd = dato[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (!b2b) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; adr = '0; dati = '0; sel = '0;
    idle(3);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d] got=%b exp=0", d, ack[d]); end
      n_checks++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got=%b exp=0", d, err[d]); end
      n_checks++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, busy[d]); end
      n_checks++; if (dato[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d] got=%h exp=0", d, dato[d]); end
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_write_read();
    int lat; logic a, e; logic [31:0] rd;
    wb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 3 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL wr10 lat=%0d ack=%b err=%b exp lat=3 ack=1 err=0", lat, a, e); end
    wb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, lat, a, e, rd);
    n_checks++; if (lat !== 3 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL rd10 lat=%0d ack=%b err=%b exp lat=3 ack=1 err=0", lat, a, e); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd10_data got=%h exp=deadbeef", rd); end
    idle(1);
    n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL ack_single got=%b exp=0", ack[0]); end
    // last implemented word
    wb_xfer(0, 1'b1, 32'h7FC, 32'h5A5A0FF0, 4'hF, 1'b0, lat, a, e, rd);
    wb_xfer(0, 1'b0, 32'h7FC, 32'h0, 4'h0, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b1 || e !== 1'b0 || rd !== 32'h5A5A0FF0) begin n_fail++; $display("FAIL rd7fc ack=%b err=%b data=%h exp ack=1 err=0 data=5a5a0ff0", a, e, rd); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic a, e; logic [31:0] rd;
    wb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, lat, a, e, rd);
    wb_xfer(0, 1'b1, 32'h20, 32'hAA000000, 4'h8, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL wr_sel8 ack=%b err=%b exp ack=1 err=0", a, e); end
    wb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h1, 1'b0, lat, a, e, rd);
    n_checks++; if (rd !== 32'hAA223344) begin n_fail++; $display("FAIL rd_lanes got=%h exp=aa223344", rd); end
    wb_xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 3 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL wr_sel0 lat=%0d ack=%b err=%b exp lat=3 ack=1 err=0", lat, a, e); end
    wb_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (rd !== 32'hAA223344) begin n_fail++; $display("FAIL rd_after_sel0 got=%h exp=aa223344", rd); end
    n_checks++; if (dato[0] !== 32'hAA223344) begin n_fail++; $display("FAIL dat_hold_idle got=%h exp=aa223344", dato[0]); end
  endtask

  task automatic test_bad_addr();
    int lat; logic a, e; logic [31:0] rd;
    wb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    wb_xfer(0, 1'b0, 32'h802, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 3 || a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL rd802 lat=%0d ack=%b err=%b exp lat=3 ack=0 err=1", lat, a, e); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd802_dat got=%h exp=deadbeef", rd); end
    wb_xfer(0, 1'b0, 32'h800, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b0 || e !== 1'b1 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd800 ack=%b err=%b dat=%h exp ack=0 err=1 dat=deadbeef", a, e, rd); end
    wb_xfer(0, 1'b1, 32'h0001_0010, 32'h12345678, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL wr_high ack=%b err=%b exp ack=0 err=1", a, e); end
    wb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd10_after_bad got=%h exp=deadbeef", rd); end
    // depth limit below the address field on the 256-word instance
    wb_xfer(1, 1'b1, 32'h3FC, 32'hC0FFEE11, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 6 || a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL d1_wr3fc lat=%0d ack=%b err=%b exp lat=6 ack=1 err=0", lat, a, e); end
    wb_xfer(1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 6 || a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL d1_rd400 lat=%0d ack=%b err=%b exp lat=6 ack=0 err=1", lat, a, e); end
    wb_xfer(1, 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (rd !== 32'hC0FFEE11) begin n_fail++; $display("FAIL d1_rd3fc got=%h exp=c0ffee11", rd); end
  endtask

  task automatic test_wait_abort();
    int lat; logic a, e; logic [31:0] rd; logic seen;
    wb_xfer(1, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 6 || a !== 1'b1) begin n_fail++; $display("FAIL d1_wr4 lat=%0d ack=%b exp lat=6 ack=1", lat, a); end
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h4; dati[1] = 32'h12345678; sel[1] = 4'hF;
    idle(1);
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL d1_busy_wait got=%b exp=1", busy[1]); end
    idle(1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      if (ack[1] || err[1]) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL d1_abort_resp got=%b exp=0", seen); end
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL d1_abort_busy got=%b exp=0", busy[1]); end
    wb_xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b1 || rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL d1_rd4 ack=%b dat=%h exp ack=1 dat=0badf00d", a, rd); end
  endtask

  task automatic test_reset_in_access();
    int lat; logic a, e; logic [31:0] rd; logic seen;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h20; sel[0] = 4'hF;
    idle(1);
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_access got=%b exp=1", busy[0]); end
    rst = 1'b1;
    idle(1);
    n_checks++; if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp ack=%b err=%b exp 0 0", ack[0], err[0]); end
    n_checks++; if (dato[0] !== 32'h0) begin n_fail++; $display("FAIL rst_dat got=%h exp=0", dato[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      if (ack[0] || err[0]) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_late_resp got=%b exp=0", seen); end
    wb_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 3 || a !== 1'b1 || rd !== 32'hAA223344) begin n_fail++; $display("FAIL rd_after_rst lat=%0d ack=%b dat=%h exp lat=3 ack=1 dat=aa223344", lat, a, rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic a, e; logic [31:0] rd;
    wb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, lat, a, e, rd);
    n_checks++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_first lat=%0d dat=%h exp lat=3 dat=deadbeef", lat, rd); end
    wb_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (lat !== 4 || a !== 1'b1 || rd !== 32'hAA223344) begin n_fail++; $display("FAIL b2b_second lat=%0d ack=%b dat=%h exp lat=4 ack=1 dat=aa223344", lat, a, rd); end
  endtask

  task automatic test_parity();
    int lat; logic a, e; logic [31:0] rd;
    wb_xfer(0, 1'b1, 32'h8, 32'hCAFE0001, 4'hF, 1'b0, lat, a, e, rd);
`ifdef WB_MEM_PARITY_EN
    dut0.u_ram.par_mem[2] = dut0.u_ram.par_mem[2] ^ 4'b0010;
    wb_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL par_err ack=%b err=%b exp ack=0 err=1", a, e); end
    n_checks++; if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL par_dat got=%h exp=cafe0001", rd); end
`else
    wb_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, lat, a, e, rd);
    n_checks++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL nopar_ack ack=%b err=%b exp ack=1 err=0", a, e); end
    n_checks++; if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL nopar_dat got=%h exp=cafe0001", rd); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    @(posedge sys_clk); #1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_bad_addr();
    test_wait_abort();
    test_reset_in_access();
    test_back_to_back();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
